// File: rtl/fmap_pkg.sv
// Shared constants and state type for the feature-map reader.
package fmap_pkg;

  localparam int unsigned NUM_CH    = 60;
  localparam int unsigned CH_PIX    = 16;
  localparam int unsigned FMAP_BITS = NUM_CH * CH_PIX;
  localparam int unsigned CH_W      = 6;

  typedef enum logic [1:0] {
    StIdle,
    StStream,
    StDone
  } rd_state_e;

endpackage

// File: rtl/fmap_reader.sv
// Snapshots a binary feature map and streams it out one channel per
// valid/ready transfer, in ascending channel order.
module fmap_reader #(
  parameter int unsigned NUM_CH = fmap_pkg::NUM_CH,
  parameter int unsigned CH_PIX = fmap_pkg::CH_PIX
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              begin_read,
  input  logic              fmap_in [0:NUM_CH*CH_PIX-1],
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CH_PIX-1:0] out_data,
  output logic [5:0]        out_chan,
  output logic              out_last,
  output logic              busy,
  output logic              done_read
);
  import fmap_pkg::*;

  localparam int unsigned Bits = NUM_CH * CH_PIX;

  rd_state_e       state_q, state_d;
  logic [5:0]      ch_cnt_q, ch_cnt_d;
  logic [Bits-1:0] snap_q, snap_d;
  logic            last_ch;

  assign last_ch = (ch_cnt_q == 6'(NUM_CH - 1));

  // Next-state, channel counter and snapshot capture.
  always_comb begin
    state_d  = state_q;
    ch_cnt_d = ch_cnt_q;
    snap_d   = snap_q;
    unique case (state_q)
      StIdle: begin
        if (begin_read) begin
          for (int k = 0; k < int'(Bits); k++) begin
            snap_d[k] = fmap_in[k];
          end
          ch_cnt_d = '0;
          state_d  = StStream;
        end
      end
      StStream: begin
        if (out_ready) begin
          ch_cnt_d = ch_cnt_q + 6'd1;
          if (last_ch) begin
            state_d = StDone;
          end
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // State registers; the snapshot is left unreset since it is only visible while streaming.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      ch_cnt_q <= '0;
    end else begin
      state_q  <= state_d;
      ch_cnt_q <= ch_cnt_d;
    end
    snap_q <= snap_d;
  end

  // Outputs decoded from registered state; data/chan are zeroed outside STREAM.
  always_comb begin
    out_valid = (state_q == StStream);
    busy      = (state_q == StStream);
    done_read = (state_q == StDone);
    out_last  = out_valid && last_ch;
    out_chan  = out_valid ? ch_cnt_q : 6'd0;
    out_data  = '0;
    if (out_valid) begin
      for (int c = 0; c < int'(NUM_CH); c++) begin
        if (ch_cnt_q == 6'(c)) begin
          out_data = snap_q[c*CH_PIX +: CH_PIX];
        end
      end
    end
  end

endmodule

// File: tb/tb_fmap_reader.sv
// Directed self-checking bench for fmap_reader.
module tb_fmap_reader;

  localparam int NCH  = 60;
  localparam int NPIX = 16;
  localparam int NB   = NCH * NPIX;

  logic        clk = 1'b0;
  logic        rst;
  logic        begin_read;
  logic        fmap_in [0:NB-1];
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_data;
  logic [5:0]  out_chan;
  logic        out_last;
  logic        busy;
  logic        done_read;

  logic        exp_snap [0:NB-1];
  int          errors = 0;
  int          checks = 0;

  fmap_reader dut (
    .clk       (clk),
    .rst       (rst),
    .begin_read(begin_read),
    .fmap_in   (fmap_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_chan  (out_chan),
    .out_last  (out_last),
    .busy      (busy),
    .done_read (done_read)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] exp_word(input int c);
    logic [15:0] w;
    for (int i = 0; i < NPIX; i++) w[i] = exp_snap[c*NPIX + i];
    return w;
  endfunction

  task automatic set_alt();
    for (int k = 0; k < NB; k++) fmap_in[k] = (k % 2 == 1);
  endtask

  task automatic set_all(input logic v);
    for (int k = 0; k < NB; k++) fmap_in[k] = v;
  endtask

  task automatic set_rand();
    for (int k = 0; k < NB; k++) fmap_in[k] = 1'($urandom_range(0, 1));
  endtask

  task automatic set_chan(input int c, input logic [15:0] v);
    for (int i = 0; i < NPIX; i++) fmap_in[c*NPIX + i] = v[i];
  endtask

  // Pulse begin_read and record the bench's own copy of the captured map.
  task automatic start_frame();
    for (int k = 0; k < NB; k++) exp_snap[k] = fmap_in[k];
    begin_read = 1'b1;
    step();
    begin_read = 1'b0;
  endtask

  // Follows a frame from the first word to the DONE cycle.
  // mode: 0 = ready always high, 1 = random ready.
  task automatic stream_check(input int mode, input int stall_chan, input int stall_len,
                              input int restart_chan, input int exp_cycles);
    int exp_c  = 0;
    int stalls = 0;
    int cyc    = 0;
    bit restarted = 0;
    while (exp_c < NCH && cyc < 2000) begin
      chk("valid", 32'(out_valid), 32'd1);
      chk("busy", 32'(busy), 32'd1);
      chk("done_in_stream", 32'(done_read), 32'd0);
      chk("chan", 32'(out_chan), 32'(exp_c));
      chk("data", 32'(out_data), 32'(exp_word(exp_c)));
      chk("last", 32'(out_last), 32'(exp_c == NCH - 1));
      if (exp_c == stall_chan && stalls < stall_len) begin
        out_ready = 1'b0;
        stalls++;
      end else if (mode == 1) begin
        out_ready = 1'($urandom_range(0, 1));
      end else begin
        out_ready = 1'b1;
      end
      if (exp_c == restart_chan && !restarted) begin
        begin_read = 1'b1;
        for (int k = 0; k < NB; k++) fmap_in[k] = ~exp_snap[k];
        restarted = 1;
      end else begin
        begin_read = 1'b0;
      end
      if (out_ready) exp_c++;
      step();
      cyc++;
    end
    begin_read = 1'b0;
    chk("frame_timeout", 32'(exp_c), 32'(NCH));
    if (exp_cycles > 0) chk("frame_cycles", 32'(cyc), 32'(exp_cycles));
    chk("done_pulse", 32'(done_read), 32'd1);
    chk("done_valid", 32'(out_valid), 32'd0);
    chk("done_busy", 32'(busy), 32'd0);
    out_ready = 1'b1;
    step();
    chk("idle_done", 32'(done_read), 32'd0);
    chk("idle_valid", 32'(out_valid), 32'd0);
  endtask

  initial begin
    rst        = 1'b1;
    begin_read = 1'b0;
    out_ready  = 1'b0;
    set_all(1'b0);

    // Reset, with begin_read and out_ready also asserted to confirm reset priority.
    step();
    begin_read = 1'b1;
    out_ready  = 1'b1;
    step();
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done_read), 32'd0);
    chk("rst_last", 32'(out_last), 32'd0);
    chk("rst_data", 32'(out_data), 32'd0);
    chk("rst_chan", 32'(out_chan), 32'd0);
    rst        = 1'b0;
    begin_read = 1'b0;
    step();

    // Full-rate readout of the alternating pattern: every word 16'hAAAA.
    set_alt();
    out_ready = 1'b1;
    start_frame();
    chk("s1_word0", 32'(out_data), 32'h0000_AAAA);
    stream_check(0, -1, 0, -1, NCH);

    // Backpressure on channel 5.
    set_rand();
    set_chan(5, 16'h1234);
    start_frame();
    chk("s2_ch5", 32'(exp_word(5)), 32'h0000_1234);
    stream_check(0, 5, 3, -1, NCH + 3);

    // Snapshot isolation: input cleared right after capture.
    set_all(1'b1);
    start_frame();
    set_all(1'b0);
    stream_check(0, -1, 0, -1, NCH);

    // Ignored restart at channel 10 with a different map on the input.
    set_rand();
    start_frame();
    stream_check(0, -1, 0, 10, NCH);

    // Reset mid-frame at channel 30.
    set_rand();
    start_frame();
    for (int c = 0; c < 30; c++) step();
    chk("s5_chan30", 32'(out_chan), 32'd30);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("s5_valid", 32'(out_valid), 32'd0);
    chk("s5_busy", 32'(busy), 32'd0);
    chk("s5_done", 32'(done_read), 32'd0);
    step();
    chk("s5_done2", 32'(done_read), 32'd0);
    set_rand();
    start_frame();
    stream_check(0, -1, 0, -1, NCH);

    // Random out_ready over 20 frames with random maps.
    for (int f = 0; f < 20; f++) begin
      set_rand();
      start_frame();
      stream_check(1, -1, 0, -1, 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fmap_reader.md
FMAP_READER -- requirements
Module: fmap_reader

Interface
REQ-001 Parameter NUM_CH, default 60: number of feature-map channels read out.
REQ-002 Parameter CH_PIX, default 16: pixels per channel (4x4 map).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 begin_read  input  1  start pulse; snapshot fmap_in and begin streaming.
REQ-006 fmap_in  input  unpacked logic [0:NUM_CH*CH_PIX-1]  binary feature map, channel-major, index = ch*16 + row*4 + col.
REQ-007 out_valid  output  1  out_data/out_chan/out_last hold a valid word.
REQ-008 out_ready  input  1  downstream accepts the word this cycle.
REQ-009 out_data  output  CH_PIX  one channel; out_data[i] = snapshot[ch*16+i].
REQ-010 out_chan  output  6  channel index of out_data, 0..NUM_CH-1.
REQ-011 out_last  output  1  high with the word for channel NUM_CH-1.
REQ-012 busy  output  1  high while in STREAM.
REQ-013 done_read  output  1  one-cycle pulse after the final transfer.

Function
REQ-014 States IDLE, STREAM, DONE; encoding is free, transitions are exactly as specified below.
REQ-015 IDLE: begin_read=1 -> capture fmap_in into an internal snapshot register, set ch_cnt=0, go to STREAM next cycle.
REQ-016 Latency: begin_read sampled at edge N -> out_valid=1 with out_chan=0 in the cycle after edge N.
REQ-017 STREAM: out_valid=1 and busy=1; out_data = snapshot channel ch_cnt; out_chan = ch_cnt.
REQ-018 Transfer occurs on an edge where out_valid=1 and out_ready=1; ch_cnt then increments by one.
REQ-019 Hold: while out_valid=1 and out_ready=0, out_data, out_chan and out_last stay unchanged.
REQ-020 Transfer with out_last=1 -> go to DONE; ch_cnt does not wrap to 0 inside STREAM.
REQ-021 DONE lasts exactly one cycle: done_read=1, out_valid=0, busy=0; then go to IDLE.
REQ-022 begin_read in STREAM or DONE is ignored; no restart and no re-snapshot.
REQ-023 Snapshot isolation: changes on fmap_in after the capture edge do not affect streamed data.
REQ-024 out_ready=1 continuously -> 60 transfers on 60 consecutive edges; done_read in the following cycle.
REQ-025 Arbitrary out_ready gaps -> exactly NUM_CH transfers in ascending channel order, with no duplicates or drops.
REQ-026 Outputs are driven from registered state only; no combinational path from out_ready to out_valid.

Reset
REQ-027 rst=1 at an edge -> state IDLE, ch_cnt=0, out_valid=0, out_last=0, busy=0, done_read=0, out_data=0, out_chan=0.
REQ-028 rst has priority over begin_read and out_ready on the same edge.
REQ-029 rst during STREAM aborts the readout; done_read is not asserted for the aborted frame.
REQ-030 The snapshot register needs no reset value; it is not observable while out_valid=0.

Structure
REQ-031 Shared package fmap_pkg holds NUM_CH, CH_PIX, FMAP_BITS (=NUM_CH*CH_PIX) and the reader state enum type.
REQ-032 No sub-module: the channel select is a parameterised mux inside fmap_reader.

Verification
REQ-033 Scenario 1, full-rate readout:
- Stimulus: fmap_in bit k = k[0]; begin_read pulse; out_ready=1.
- Required response: every out_data = 16'hAAAA (out_data[i] = i[0], so odd bits set); out_chan runs 0..59 on consecutive cycles; out_last only at chan 59; done_read 61 cycles after begin_read.
REQ-034 Scenario 2, backpressure:
- Stimulus: channel 5 = 16'h1234; out_ready low for 3 cycles while out_chan=5.
- Required response: out_data=16'h1234 and out_chan=5 stay held for all 3 cycles; chan 6 appears only after the accepting edge.
REQ-035 Scenario 3, snapshot isolation:
- Stimulus: fmap_in all ones at begin_read, then switched to all zeros on the next cycle.
- Required response: all 60 words = 16'hFFFF.
REQ-036 Scenario 4, ignored restart:
- Stimulus: second begin_read at out_chan=10.
- Required response: no restart; sequence continues 11..59; exactly one done_read pulse.
REQ-037 Scenario 5, reset mid-frame:
- Stimulus: rst at out_chan=30.
- Required response: next cycle out_valid=0, busy=0, no done_read; a new begin_read restarts at chan 0.
REQ-038 Scenario 6, random out_ready:
- Stimulus: random out_ready, 50% duty, 20 frames.
- Required response: scoreboard sees 60 words per frame in order, each matching its snapshot.
